uart_imem_loader: RTL and testbench
===================================

Name: uart_imem_loader

Overview:
Downstream consumer of the UART receiver's byte stream (rx_dv / rx_byte).
- Frames a small load protocol: sync byte, 16-bit little-endian word count, then little-endian 32-bit instruction words.
- Writes each assembled word into instruction memory at incrementing word addresses.
- Holds the core in reset while a load is in progress.
- Sits between uart_rx and the instruction memory / CPU reset logic.

Parameters:
ADDR_WIDTH, 10, instruction memory word-address width; capacity is 2**ADDR_WIDTH words.
TIMEOUT_CYCLES, 1000000, maximum clk cycles allowed between accepted bytes while a frame is open.
SYNC_BYTE, 8'hA5, start-of-frame marker.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
rx_dv  in  1  one-cycle strobe; rx_byte is valid this cycle
rx_byte  in  8  received byte
imem_we  out  1  one-cycle instruction memory write strobe
imem_addr  out  ADDR_WIDTH  word address for the write
imem_wdata  out  32  little-endian assembled word
cpu_hold  out  1  holds the CPU in reset while high
busy  out  1  high when a frame is open (state != IDLE)
done  out  1  one-cycle pulse on successful load
err  out  1  sticky error flag; cleared when the next sync byte is accepted

Behaviour:
- Reset is asynchronous and active-high on rst; all logic runs on the single clock clk.
- Reset values: imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=0, busy=0, done=0, err=0, state=IDLE, all counters 0.
- Asserting rst mid-frame aborts the frame; no further writes; all outputs return to their reset values.

State machine: IDLE, LEN_LO, LEN_HI, DATA, CSUM (only with the optional feature).
- IDLE: on rx_dv with rx_byte==SYNC_BYTE:
  - go to LEN_LO;
  - cpu_hold<=1, err<=0;
  - clear word address, byte index and checksum.
  - Any other byte is ignored.
- LEN_LO: on rx_dv, len[7:0]<=rx_byte; go to LEN_HI.
- LEN_HI: on rx_dv, len[15:8]<=rx_byte; evaluate the completed length:
  - len > 2**ADDR_WIDTH: err<=1, go to IDLE, no writes.
  - len == 0: finish immediately (go to CSUM if enabled, else done pulse and IDLE).
  - otherwise: go to DATA.
- DATA: each rx_dv deposits rx_byte into word byte lane byte_idx (0→[7:0], 1→[15:8], 2→[23:16], 3→[31:24]); byte_idx wraps 3→0.
  - On the rx_dv that fills lane 3: in the next cycle imem_we=1 for exactly one cycle, with imem_wdata = the full word and imem_addr = the current word index.
  - Word index increments after each write.
  - After the write of word len-1: go to CSUM (if enabled), else pulse done in the same cycle as that final imem_we and go to IDLE.
- cpu_hold falls the cycle after done. After an error it stays 1 until a later successful load.
- busy = (state != IDLE).
- Timeout: while busy, a counter clears on every rx_dv. If it reaches TIMEOUT_CYCLES-1 with no rx_dv: err<=1, go to IDLE. Partial writes are not undone.
- rx_dv on consecutive cycles is accepted; no byte is dropped.
- imem_addr holds its last value between writes.
- err stays high across IDLE until the next accepted sync byte.

Optional Feature:
Macro: UART_IMEM_LOADER_CHECKSUM_EN.
- Defined: CSUM state is present. A running XOR of all DATA bytes is kept. After the last word, one further byte is expected.
  - On its rx_dv: if equal to the running XOR, done pulses in the next cycle; otherwise err<=1 and no done.
  - Either way, go to IDLE.
  - Timeout applies in CSUM.
- Undefined: no CSUM state, no checksum logic; done timing as in DATA above.

Test Plan:
1. Reset, then bytes A5 01 00 93 00 50 00 → one imem_we, addr=0, wdata=32'h00500093; done pulse; cpu_hold 1→0; err=0. With CHECKSUM_EN, append C3 → same result.
2. A5 02 00 then 8 data bytes 13 00 00 00 B3 00 11 00 → writes 32'h00000013 @0, 32'h001100B3 @1; exactly two imem_we; done after the second.
3. Bytes 00 FF 12 before A5 → ignored, busy stays 0. Then A5 00 00 → no writes; done (checksum byte 00 required if enabled).
4. A5 01 04 with ADDR_WIDTH=10 (len=1025) → err=1, no imem_we, back to IDLE, cpu_hold=1. Next good frame clears err and drops cpu_hold.
5. A5 01 00 93 00, then silence for TIMEOUT_CYCLES (set to 100) → err=1 at cycle ~99, IDLE, no write. Also: rst asserted mid-DATA → all outputs 0 immediately.
6. CHECKSUM_EN: A5 01 00 93 00 50 00 FF → write occurs, err=1, no done pulse.

Source files
------------

// File: rtl/uart_imem_loader.sv
// uart_imem_loader
// ----------------
// Consumes the byte stream from a UART receiver and loads instruction memory.
// Frame format: SYNC_BYTE, word count (16-bit little-endian), then that many
// 32-bit little-endian instruction words. While a frame is being loaded the
// CPU is held in reset. Writes go to consecutive word addresses from 0.
//
// Optional feature (macro UART_IMEM_LOADER_CHECKSUM_EN): a trailing byte
// equal to the XOR of all data bytes must follow the last word; done only
// pulses if it matches, otherwise err is raised.
//
// Ports:
//   clk         system clock
//   rst         asynchronous active-high reset
//   rx_dv       one-cycle strobe, rx_byte valid
//   rx_byte     received byte
//   imem_we     one-cycle instruction memory write strobe
//   imem_addr   word address of the write (holds between writes)
//   imem_wdata  assembled 32-bit word
//   cpu_hold    holds the CPU in reset while high
//   busy        a frame is open
//   done        one-cycle pulse on a successful load
//   err         sticky error (length overflow, timeout, bad checksum);
//               cleared when the next sync byte is accepted
//
// Word counts up to 2**ADDR_WIDTH are accepted; ADDR_WIDTH must be <= 16.

module uart_imem_loader #(
    parameter int          ADDR_WIDTH     = 10,
    parameter int          TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_dv,
    input  logic [7:0]            rx_byte,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0]   LEN_MAX = 17'(1) << ADDR_WIDTH;

`ifdef UART_IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CSUM} state_t;
`else
    typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA} state_t;
`endif

    state_t                state_reg, state_next;
    logic [15:0]           len_reg, len_next;
    logic [15:0]           word_cnt_reg, word_cnt_next;
    logic [1:0]            byte_idx_reg, byte_idx_next;
    logic [23:0]           word_buf_reg, word_buf_next;
    logic [TW-1:0]         to_cnt_reg, to_cnt_next;
    logic                  we_reg, we_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [31:0]           wdata_reg, wdata_next;
    logic                  hold_reg, hold_next;
    logic                  done_reg, done_next;
    logic                  err_reg, err_next;
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
    logic [7:0]            csum_reg, csum_next;
`endif

    logic [16:0] len_full;
    logic [23:0] lane_next;
    logic        last_word;

    // Length as it stands once the high byte arrives; one extra bit so the
    // comparison against 2**ADDR_WIDTH cannot overflow.
    assign len_full  = {1'b0, rx_byte, len_reg[7:0]};
    assign last_word = (word_cnt_reg == len_reg - 16'd1);

    // Lanes 0..2 are buffered; lane 3 goes straight into the write data.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_lane
            assign lane_next[gi*8 +: 8] =
                (state_reg == DATA && rx_dv && byte_idx_reg == 2'(gi))
                    ? rx_byte : word_buf_reg[gi*8 +: 8];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            len_reg      <= '0;
            word_cnt_reg <= '0;
            byte_idx_reg <= '0;
            word_buf_reg <= '0;
            to_cnt_reg   <= '0;
            we_reg       <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            hold_reg     <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
            csum_reg     <= '0;
`endif
        end else begin
            state_reg    <= state_next;
            len_reg      <= len_next;
            word_cnt_reg <= word_cnt_next;
            byte_idx_reg <= byte_idx_next;
            word_buf_reg <= word_buf_next;
            to_cnt_reg   <= to_cnt_next;
            we_reg       <= we_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            hold_reg     <= hold_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
            csum_reg     <= csum_next;
`endif
        end
    end

    always_comb begin
        state_next    = state_reg;
        len_next      = len_reg;
        word_cnt_next = word_cnt_reg;
        byte_idx_next = byte_idx_reg;
        word_buf_next = lane_next;
        we_next       = 1'b0;
        addr_next     = addr_reg;
        wdata_next    = wdata_reg;
        done_next     = 1'b0;
        err_next      = err_reg;
        // The CPU is released the cycle after done; a new sync below wins.
        hold_next     = done_reg ? 1'b0 : hold_reg;
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
        csum_next     = csum_reg;
`endif

        // Inactivity counter restarts on every accepted byte.
        if (state_reg == IDLE || rx_dv) begin
            to_cnt_next = '0;
        end else begin
            to_cnt_next = to_cnt_reg + 1'b1;
        end

        case (state_reg)
            IDLE: begin
                if (rx_dv && rx_byte == SYNC_BYTE) begin
                    state_next    = LEN_LO;
                    hold_next     = 1'b1;
                    err_next      = 1'b0;
                    word_cnt_next = '0;
                    byte_idx_next = '0;
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
                    csum_next     = '0;
`endif
                end
            end
            LEN_LO: begin
                if (rx_dv) begin
                    len_next[7:0] = rx_byte;
                    state_next    = LEN_HI;
                end
            end
            LEN_HI: begin
                if (rx_dv) begin
                    len_next[15:8] = rx_byte;
                    if (len_full > LEN_MAX) begin
                        err_next   = 1'b1;
                        state_next = IDLE;
                    end else if (len_full == 17'd0) begin
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
                        state_next = CSUM;
`else
                        done_next  = 1'b1;
                        state_next = IDLE;
`endif
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (rx_dv) begin
                    byte_idx_next = byte_idx_reg + 2'd1;
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
                    csum_next     = csum_reg ^ rx_byte;
`endif
                    if (byte_idx_reg == 2'd3) begin
                        we_next       = 1'b1;
                        wdata_next    = {rx_byte, word_buf_reg};
                        addr_next     = word_cnt_reg[ADDR_WIDTH-1:0];
                        word_cnt_next = word_cnt_reg + 16'd1;
                        if (last_word) begin
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
                            state_next = CSUM;
`else
                            done_next  = 1'b1;
                            state_next = IDLE;
`endif
                        end
                    end
                end
            end
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
            CSUM: begin
                if (rx_dv) begin
                    if (rx_byte == csum_reg) begin
                        done_next = 1'b1;
                    end else begin
                        err_next  = 1'b1;
                    end
                    state_next = IDLE;
                end
            end
`endif
            default: state_next = IDLE;
        endcase

        // Timeout abandons the frame; words already written stay written.
        if (state_reg != IDLE && !rx_dv && to_cnt_reg == TO_LAST) begin
            err_next   = 1'b1;
            state_next = IDLE;
        end
    end

    assign imem_we    = we_reg;
    assign imem_addr  = addr_reg;
    assign imem_wdata = wdata_reg;
    assign cpu_hold   = hold_reg;
    assign busy       = (state_reg != IDLE);
    assign done       = done_reg;
    assign err        = err_reg;

endmodule

// File: tb/tb_uart_imem_loader.sv
// Testbench for uart_imem_loader: directed frames from the test plan plus
// randomized frames, checked against a frame-level reference model.
module tb_uart_imem_loader;

    localparam int AW  = 10;
    localparam int TMO = 100;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx_dv = 1'b0;
    logic [7:0]    rx_byte = 8'h00;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_hold;
    logic          busy;
    logic          done;
    logic          err;

    uart_imem_loader #(
        .ADDR_WIDTH(AW),
        .TIMEOUT_CYCLES(TMO),
        .SYNC_BYTE(8'hA5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_dv(rx_dv),
        .rx_byte(rx_byte),
        .imem_we(imem_we),
        .imem_addr(imem_addr),
        .imem_wdata(imem_wdata),
        .cpu_hold(cpu_hold),
        .busy(busy),
        .done(done),
        .err(err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Monitor: records writes and done pulses, sampled on the falling edge.
    int          cyc = 0;
    logic [AW-1:0] mon_addr[$];
    logic [31:0] mon_data[$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          last_we_cyc = 0;

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            mon_addr.push_back(imem_addr);
            mon_data.push_back(imem_wdata);
            last_we_cyc = cyc;
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        cyc++;
    end

    // Reference model (frame level).
    logic [7:0]  frame_q[$];
    logic [31:0] exp_data[$];
    int          exp_len;
    bit          exp_done;
    bit          exp_err;

    task automatic model_frame();
        int s;
        logic [7:0] x;
        exp_data.delete();
        exp_done = 0;
        exp_err  = 0;
        exp_len  = 0;
        s = 0;
        while (s < frame_q.size() && frame_q[s] != 8'hA5) s++;
        exp_len = int'(frame_q[s+1]) + 256 * int'(frame_q[s+2]);
        if (exp_len > (1 << AW)) begin
            exp_err = 1;
            exp_len = 0;
            return;
        end
        x = 8'h00;
        for (int w = 0; w < exp_len; w++) begin
            logic [31:0] word;
            word = '0;
            for (int b = 0; b < 4; b++) begin
                word = word | (32'(frame_q[s + 3 + 4*w + b]) << (8*b));
                x = x ^ frame_q[s + 3 + 4*w + b];
            end
            exp_data.push_back(word);
        end
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
        if (frame_q[s + 3 + 4*exp_len] == x) exp_done = 1;
        else exp_err = 1;
`else
        exp_done = 1;
`endif
    endtask

    // Caller is always 1ns after a rising edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_dv = 1'b1;
        rx_byte = b;
        @(posedge clk);
        #1;
        rx_dv = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_monitor();
        mon_addr.delete();
        mon_data.delete();
        done_cnt = 0;
        done_cyc = -1;
        last_we_cyc = -1;
    endtask

    task automatic run_frame(input string name, input int gap_max);
        model_frame();
        clear_monitor();
        for (int i = 0; i < frame_q.size(); i++) begin
            send_byte(frame_q[i], $urandom_range(0, gap_max));
            if (i == 0 && frame_q[0] == 8'hA5) begin
                vectors++;
                if ({cpu_hold, busy} !== 2'b11) begin
                    miscompares++;
                    $display("FAIL %s hold_busy_after_sync got %b exp 11", name, {cpu_hold, busy});
                end
            end
        end
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        vectors++;
        if (mon_addr.size() !== exp_data.size()) begin
            miscompares++;
            $display("FAIL %s write_count got %0d exp %0d", name, mon_addr.size(), exp_data.size());
        end
        for (int i = 0; i < exp_data.size() && i < mon_addr.size(); i++) begin
            vectors++;
            if (mon_addr[i] !== AW'(i) || mon_data[i] !== exp_data[i]) begin
                miscompares++;
                $display("FAIL %s write%0d got %h@%0d exp %h@%0d", name, i, mon_data[i], mon_addr[i], exp_data[i], i);
            end
        end
        vectors++;
        if (done_cnt !== (exp_done ? 1 : 0)) begin
            miscompares++;
            $display("FAIL %s done_count got %0d exp %0d", name, done_cnt, exp_done ? 1 : 0);
        end
        vectors++;
        if ({err, cpu_hold, busy} !== {exp_err, !exp_done, 1'b0}) begin
            miscompares++;
            $display("FAIL %s err_hold_busy got %b exp %b", name, {err, cpu_hold, busy}, {exp_err, !exp_done, 1'b0});
        end
        if (exp_done && exp_len > 0) begin
            vectors++;
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
            if (done_cyc <= last_we_cyc) begin
`else
            if (done_cyc !== last_we_cyc) begin
`endif
                miscompares++;
                $display("FAIL %s done_timing got done@%0d last_we@%0d", name, done_cyc, last_we_cyc);
            end
        end
        $display("frame %s: len=%0d writes=%0d done=%0d err=%b hold=%b", name, exp_len, mon_addr.size(), done_cnt, err, cpu_hold);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({imem_we, imem_addr, imem_wdata, cpu_hold, busy, done, err} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got we=%b addr=%h wdata=%h hold=%b busy=%b done=%b err=%b exp all 0",
                     imem_we, imem_addr, imem_wdata, cpu_hold, busy, done, err);
        end
        rst = 1'b0;
        $display("reset released");
    endtask

    task automatic test_single_word();
        frame_q = '{8'hA5, 8'h01, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00};
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
        frame_q.push_back(8'hC3);
`endif
        run_frame("single_word", 2);
        vectors++;
        if (exp_data.size() != 1 || exp_data[0] !== 32'h00500093) begin
            miscompares++;
            $display("FAIL model_single_word got %0d words exp 00500093", exp_data.size());
        end
    endtask

    task automatic test_two_words();
        frame_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                    8'hB3, 8'h00, 8'h11, 8'h00};
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
        frame_q.push_back(8'h13 ^ 8'hB3 ^ 8'h11);
`endif
        run_frame("two_words", 1);
    endtask

    task automatic test_ignore_and_empty();
        logic [7:0] noise[3] = '{8'h00, 8'hFF, 8'h12};
        clear_monitor();
        for (int i = 0; i < 3; i++) begin
            send_byte(noise[i], 1);
            vectors++;
            if (busy !== 1'b0 || cpu_hold !== 1'b0) begin
                miscompares++;
                $display("FAIL ignore_byte_%0d busy=%b hold=%b exp 0 0", i, busy, cpu_hold);
            end
        end
        frame_q = '{8'hA5, 8'h00, 8'h00};
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
        frame_q.push_back(8'h00);
`endif
        run_frame("empty", 0);
    endtask

    task automatic test_len_overflow();
        frame_q = '{8'hA5, 8'h01, 8'h04};
        run_frame("len_1025", 1);
        frame_q = '{8'hA5, 8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
        frame_q.push_back(8'h44 ^ 8'h33 ^ 8'h22 ^ 8'h11);
`endif
        run_frame("recover_after_err", 0);
    endtask

    task automatic test_timeout();
        int n;
        logic [7:0] part[5] = '{8'hA5, 8'h01, 8'h00, 8'h93, 8'h00};
        clear_monitor();
        for (int i = 0; i < 5; i++) send_byte(part[i], 0);
        n = 0;
        while (err !== 1'b1 && n < 3 * TMO) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n < TMO - 5 || n > TMO + 5) begin
            miscompares++;
            $display("FAIL timeout_latency got %0d cycles exp about %0d", n, TMO);
        end
        @(posedge clk);
        #1;
        vectors++;
        if ({err, busy, cpu_hold} !== 3'b101 || mon_addr.size() != 0 || done_cnt != 0) begin
            miscompares++;
            $display("FAIL timeout_state got err=%b busy=%b hold=%b writes=%0d done=%0d exp 1 0 1 0 0",
                     err, busy, cpu_hold, mon_addr.size(), done_cnt);
        end
        $display("timeout: err after %0d cycles", n);
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] part[9] = '{8'hA5, 8'h02, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h01, 8'h02};
        clear_monitor();
        for (int i = 0; i < 9; i++) send_byte(part[i], 0);
        vectors++;
        if (mon_addr.size() != 1 || imem_wdata !== 32'hDEADBEEF || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset got writes=%0d wdata=%h busy=%b exp 1 deadbeef 1", mon_addr.size(), imem_wdata, busy);
        end
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if ({imem_we, imem_addr, imem_wdata, cpu_hold, busy, done, err} !== '0) begin
            miscompares++;
            $display("FAIL async_reset got we=%b addr=%h wdata=%h hold=%b busy=%b done=%b err=%b exp all 0",
                     imem_we, imem_addr, imem_wdata, cpu_hold, busy, done, err);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_monitor();
        send_byte(8'h03, 0);
        send_byte(8'h04, 2);
        vectors++;
        if (mon_addr.size() != 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL after_abort got writes=%0d busy=%b exp 0 0", mon_addr.size(), busy);
        end
        $display("reset mid-frame checked");
    endtask

`ifdef UART_IMEM_LOADER_CHECKSUM_EN
    task automatic test_bad_checksum();
        frame_q = '{8'hA5, 8'h01, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'hFF};
        run_frame("bad_checksum", 1);
    endtask
`endif

    task automatic build_random(input int len, input bit bad_csum);
        logic [7:0] x;
        logic [7:0] b;
        frame_q = '{8'hA5, 8'(len), 8'(len >> 8)};
        x = 8'h00;
        for (int i = 0; i < 4 * len; i++) begin
            b = 8'($urandom);
            x = x ^ b;
            frame_q.push_back(b);
        end
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
        frame_q.push_back(bad_csum ? (x ^ 8'h5A) : x);
`else
        if (bad_csum) frame_q.push_back(8'h00);
`endif
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            build_random($urandom_range(1, 6), ($urandom_range(0, 3) == 0));
            run_frame($sformatf("random%0d", k), 3);
        end
    endtask

    task automatic test_back_to_back();
        build_random(20, 1'b0);
        run_frame("back_to_back", 0);
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_two_words();
        test_ignore_and_empty();
        test_len_overflow();
        test_timeout();
        test_reset_mid_frame();
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
        test_bad_checksum();
`endif
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
